// File: rtl/conv3x3_icb_engine.sv
// 3x3 zero-padded convolution engine: fetches weights and image rows over ICB,
// keeps a 3-row rotating line buffer and writes packed int8 result planes back.
module conv3x3_icb_engine #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int OUT_CH = 16,
    parameter int ACC_W  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] cfg_wgt_base,
    input  logic [31:0] cfg_inp_base,
    input  logic [31:0] cfg_out_base,
    input  logic [3:0]  cfg_shift,
    input  logic        cfg_relu,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        conv_icb_cmd_valid,
    input  logic        conv_icb_cmd_ready,
    output logic [31:0] conv_icb_cmd_addr,
    output logic        conv_icb_cmd_read,
    output logic [31:0] conv_icb_cmd_wdata,
    output logic [3:0]  conv_icb_cmd_wmask,
    input  logic        conv_icb_rsp_valid,
    output logic        conv_icb_rsp_ready,
    input  logic [31:0] conv_icb_rsp_rdata,
    input  logic        conv_icb_rsp_err
);
    localparam int WPR = IMG_W / 4;
    localparam int JW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int YW  = $clog2(IMG_H + 1);
    localparam int CW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = 127;
    localparam logic signed [ACC_W-1:0] SAT_LO = -128;

    typedef enum logic [2:0] {IDLE, RD_WGT, RD_ROW, CALC, WR_OUT} state_t;
    state_t state_reg, state_next;

    logic          start_d_reg, wait_rsp_reg, done_reg, err_reg;
    logic [31:0]   wgt_base_reg, inp_base_reg, out_base_reg;
    logic [3:0]    shift_reg;
    logic          relu_reg;
    logic [CW-1:0] ch_reg;
    logic [YW-1:0] y_reg, fetch_row_reg;
    logic [JW-1:0] j_reg;
    logic [1:0]    k_reg, fill_slot_reg, cur_slot_reg;
    logic [23:0]   wgt_reg [3];
    logic [31:0]   lbuf_reg [3][WPR];
    logic [31:0]   wdata_reg;
    logic [31:0]   calc_word;

    logic start_acc, cmd_fire, rsp_fire, last_j, last_y, last_ch;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign start_acc = (state_reg == IDLE) && start && !start_d_reg;
    assign cmd_fire  = conv_icb_cmd_valid && conv_icb_cmd_ready;
    assign rsp_fire  = wait_rsp_reg && conv_icb_rsp_valid;
    assign last_j    = (j_reg == JW'(WPR - 1));
    assign last_y    = (y_reg == YW'(IMG_H - 1));
    assign last_ch   = (ch_reg == CW'(OUT_CH - 1));

    assign busy               = (state_reg != IDLE);
    assign done               = done_reg;
    assign err                = err_reg;
    assign conv_icb_cmd_wdata = wdata_reg;
    assign conv_icb_rsp_ready = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start_acc) state_next = RD_WGT;
            RD_WGT: if (rsp_fire) begin
                if (conv_icb_rsp_err)   state_next = IDLE;
                else if (k_reg == 2'd2) state_next = RD_ROW;
            end
            // Only the very first row fetch of a channel is followed by another one
            RD_ROW: if (rsp_fire) begin
                if (conv_icb_rsp_err)                      state_next = IDLE;
                else if (last_j && fetch_row_reg != '0)    state_next = CALC;
            end
            CALC:   state_next = WR_OUT;
            WR_OUT: if (rsp_fire) begin
                if (conv_icb_rsp_err) state_next = IDLE;
                else if (!last_j)     state_next = CALC;
                else if (!last_y)     state_next = (fetch_row_reg < YW'(IMG_H)) ? RD_ROW : CALC;
                else if (!last_ch)    state_next = RD_WGT;
                else                  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        conv_icb_cmd_valid = 1'b0;
        conv_icb_cmd_read  = 1'b0;
        conv_icb_cmd_wmask = 4'h0;
        conv_icb_cmd_addr  = 32'd0;
        case (state_reg)
            RD_WGT: begin
                conv_icb_cmd_valid = !wait_rsp_reg;
                conv_icb_cmd_read  = 1'b1;
                conv_icb_cmd_addr  = wgt_base_reg + 32'(ch_reg) * 32'd12 + {28'd0, k_reg, 2'b00};
            end
            RD_ROW: begin
                conv_icb_cmd_valid = !wait_rsp_reg;
                conv_icb_cmd_read  = 1'b1;
                conv_icb_cmd_addr  = inp_base_reg + 32'(fetch_row_reg) * 32'(IMG_W) + 32'({j_reg, 2'b00});
            end
            WR_OUT: begin
                conv_icb_cmd_valid = !wait_rsp_reg;
                conv_icb_cmd_wmask = 4'hF;
                conv_icb_cmd_addr  = out_base_reg + 32'(ch_reg) * 32'(IMG_W * IMG_H)
                                   + 32'(y_reg) * 32'(IMG_W) + 32'({j_reg, 2'b00});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d_reg   <= 1'b0;
            wait_rsp_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            wgt_base_reg  <= '0;
            inp_base_reg  <= '0;
            out_base_reg  <= '0;
            shift_reg     <= '0;
            relu_reg      <= 1'b0;
            ch_reg        <= '0;
            y_reg         <= '0;
            fetch_row_reg <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            fill_slot_reg <= '0;
            cur_slot_reg  <= '0;
            wdata_reg     <= '0;
            for (int s = 0; s < 3; s++) begin
                wgt_reg[s] <= '0;
                for (int w = 0; w < WPR; w++) lbuf_reg[s][w] <= '0;
            end
        end else begin
            start_d_reg <= start;
            done_reg    <= 1'b0;
            if (start_acc) begin
                wgt_base_reg  <= cfg_wgt_base;
                inp_base_reg  <= cfg_inp_base;
                out_base_reg  <= cfg_out_base;
                shift_reg     <= cfg_shift;
                relu_reg      <= cfg_relu;
                err_reg       <= 1'b0;
                wait_rsp_reg  <= 1'b0;
                ch_reg        <= '0;
                y_reg         <= '0;
                fetch_row_reg <= '0;
                j_reg         <= '0;
                k_reg         <= '0;
                fill_slot_reg <= '0;
                cur_slot_reg  <= '0;
            end
            if (cmd_fire) wait_rsp_reg <= 1'b1;
            if (rsp_fire) begin
                wait_rsp_reg <= 1'b0;
                if (conv_icb_rsp_err) begin
                    err_reg <= 1'b1;
                end else begin
                    case (state_reg)
                        RD_WGT: begin
                            wgt_reg[k_reg] <= conv_icb_rsp_rdata[23:0];
                            k_reg <= (k_reg == 2'd2) ? 2'd0 : k_reg + 2'd1;
                        end
                        RD_ROW: begin
                            lbuf_reg[fill_slot_reg][j_reg] <= conv_icb_rsp_rdata;
                            if (last_j) begin
                                j_reg         <= '0;
                                fetch_row_reg <= fetch_row_reg + 1'b1;
                                fill_slot_reg <= slot_inc(fill_slot_reg);
                            end else begin
                                j_reg <= j_reg + 1'b1;
                            end
                        end
                        WR_OUT: begin
                            if (!last_j) begin
                                j_reg <= j_reg + 1'b1;
                            end else begin
                                j_reg <= '0;
                                if (!last_y) begin
                                    y_reg        <= y_reg + 1'b1;
                                    cur_slot_reg <= slot_inc(cur_slot_reg);
                                end else begin
                                    y_reg <= '0;
                                    if (!last_ch) begin
                                        ch_reg        <= ch_reg + 1'b1;
                                        fetch_row_reg <= '0;
                                        fill_slot_reg <= '0;
                                        cur_slot_reg  <= '0;
                                    end else begin
                                        done_reg <= 1'b1;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (state_reg == CALC) wdata_reg <= calc_word;
        end
    end

    // Window rows 0/1/2 map to image rows y-1/y/y+1; out-of-image rows read as zero
    logic [1:0]    row_slot [3];
    logic          row_ok   [3];
    logic [JW-1:0] j_prev, j_succ;
    logic [47:0]   win      [3];

    assign row_slot[0] = (cur_slot_reg == 2'd0) ? 2'd2 : cur_slot_reg - 2'd1;
    assign row_slot[1] = cur_slot_reg;
    assign row_slot[2] = slot_inc(cur_slot_reg);
    assign row_ok[0]   = (y_reg != '0);
    assign row_ok[1]   = 1'b1;
    assign row_ok[2]   = !last_y;
    assign j_prev      = (j_reg == '0) ? '0 : j_reg - 1'b1;
    assign j_succ      = last_j ? j_reg : j_reg + 1'b1;

    genvar gi;
    generate
        // Byte 0 is pixel 4j-1, bytes 1..4 the word itself, byte 5 pixel 4j+4
        for (gi = 0; gi < 3; gi++) begin : g_win
            assign win[gi] = row_ok[gi] ?
                {(last_j ? 8'd0 : lbuf_reg[row_slot[gi]][j_succ][7:0]),
                 lbuf_reg[row_slot[gi]][j_reg],
                 ((j_reg == '0) ? 8'd0 : lbuf_reg[row_slot[gi]][j_prev][31:24])} : 48'd0;
        end

        for (gi = 0; gi < 4; gi++) begin : g_px
            logic signed [15:0]      prod;
            logic signed [ACC_W-1:0] acc;
            logic signed [ACC_W-1:0] shifted;
            logic [7:0]              px;
            always_comb begin
                prod = '0;
                acc  = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        prod = $signed(win[r][8*(gi+c) +: 8]) * $signed(wgt_reg[r][8*c +: 8]);
                        acc  = acc + {{(ACC_W-16){prod[15]}}, prod};
                    end
                end
                shifted = acc >>> shift_reg;
                if (relu_reg && shifted[ACC_W-1]) shifted = '0;
                if (shifted > SAT_HI)      px = 8'h7F;
                else if (shifted < SAT_LO) px = 8'h80;
                else                       px = shifted[7:0];
            end
            assign calc_word[8*gi +: 8] = px;
        end
    endgenerate
endmodule

// File: tb/tb_conv3x3_icb_engine.sv
// Directed bench for conv3x3_icb_engine on an 8x4 image, 2 channels, with an ICB memory model.
`timescale 1ns/1ps
module tb_conv3x3_icb_engine;
    localparam int W = 8, H = 4, NC = 2;
    localparam int WB = 0, IB = 64, OB = 128;  // word indices of the three regions

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] cfg_wgt_base = 32'h000, cfg_inp_base = 32'h100, cfg_out_base = 32'h200;
    logic [3:0]  cfg_shift = 4'd0;
    logic        cfg_relu = 1'b0;
    logic        busy, done, err;
    logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wmask;

    conv3x3_icb_engine #(.IMG_W(W), .IMG_H(H), .OUT_CH(NC), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_wgt_base(cfg_wgt_base), .cfg_inp_base(cfg_inp_base), .cfg_out_base(cfg_out_base),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .err(err),
        .conv_icb_cmd_valid(cmd_valid), .conv_icb_cmd_ready(cmd_ready),
        .conv_icb_cmd_addr(cmd_addr), .conv_icb_cmd_read(cmd_read),
        .conv_icb_cmd_wdata(cmd_wdata), .conv_icb_cmd_wmask(cmd_wmask),
        .conv_icb_rsp_valid(rsp_valid), .conv_icb_rsp_ready(rsp_ready),
        .conv_icb_rsp_rdata(rsp_rdata), .conv_icb_rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int  checks = 0, errors = 0;
    int  n_fire = 0, n_done = 0, viol = 0, rsp_cnt = 0, err_at = -1;
    bit  bp_en = 1'b0;

    // Memory model: one command at a time, optional backpressure and response delay
    initial begin : responder
        bit          fire, pend, prev_stall;
        int          dly;
        logic [31:0] c_addr, c_wdata, s_addr, s_wdata;
        logic        c_read, s_read;
        pend = 0; prev_stall = 0; dly = 0;
        c_addr = 0; c_wdata = 0; c_read = 0; s_addr = 0; s_wdata = 0; s_read = 0;
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            fire = !rst && cmd_valid && cmd_ready;
            if (prev_stall && !rst &&
                (!cmd_valid || cmd_addr !== s_addr || cmd_read !== s_read || cmd_wdata !== s_wdata))
                viol++;
            prev_stall = !rst && cmd_valid && !cmd_ready;
            s_addr = cmd_addr; s_read = cmd_read; s_wdata = cmd_wdata;
            if (cmd_valid && pend) viol++;
            if (done) n_done++;
            if (fire) begin
                n_fire++;
                c_addr = cmd_addr; c_read = cmd_read; c_wdata = cmd_wdata;
                if (cmd_wmask !== (cmd_read ? 4'h0 : 4'hF)) viol++;
            end
            @(posedge clk); #1;
            rsp_valid = 1'b0; rsp_err = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (fire) begin
                    pend = 1;
                    dly = bp_en ? int'($urandom_range(0, 7)) : 0;
                end
                if (pend) begin
                    if (dly == 0) begin
                        rsp_cnt++;
                        if (c_read) rsp_rdata = mem[c_addr[9:2]];
                        else        mem[c_addr[9:2]] = c_wdata;
                        rsp_valid = 1'b1;
                        rsp_err = (rsp_cnt == err_at);
                        pend = 0;
                    end else begin
                        dly--;
                    end
                end
            end
            cmd_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ramp_word(input int y, input int j);
        int v;
        v = y * W + 4 * j;
        return {8'(v + 3), 8'(v + 2), 8'(v + 1), 8'(v)};
    endfunction

    // Constant image/kernels: every output is (valid neighbours)*w*p, then shift/relu/saturate
    function automatic logic [7:0] exp_px(input int x, input int y, input int w, input int p,
                                          input int sh, input bit rl);
        int nr, nc, s;
        nr = 3 - ((y == 0) ? 1 : 0) - ((y == H - 1) ? 1 : 0);
        nc = 3 - ((x == 0) ? 1 : 0) - ((x == W - 1) ? 1 : 0);
        s = (nr * nc * w * p) >>> sh;
        if (rl && s < 0) s = 0;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic load_const(input logic [7:0] wv, input logic [7:0] pv);
        for (int i = 0; i < 3 * NC; i++) mem[WB + i] = {8'hAA, wv, wv, wv};
        for (int i = 0; i < H * W / 4; i++) mem[IB + i] = {pv, pv, pv, pv};
        for (int i = 0; i < NC * H * W / 4; i++) mem[OB + i] = 32'hDEADBEEF;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 3 * NC; i++) mem[WB + i] = ((i % 3) == 1) ? 32'hAA000100 : 32'hAA000000;
        for (int y = 0; y < H; y++)
            for (int j = 0; j < W / 4; j++) mem[IB + y * 2 + j] = ramp_word(y, j);
        for (int i = 0; i < NC * H * W / 4; i++) mem[OB + i] = 32'hDEADBEEF;
    endtask

    task automatic chk_ramp(input string tag);
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < H; y++)
                for (int j = 0; j < W / 4; j++)
                    chk($sformatf("%s c%0d y%0d j%0d", tag, c, y, j),
                        mem[OB + c * 8 + y * 2 + j], ramp_word(y, j));
    endtask

    task automatic chk_const(input string tag, input int w, input int p, input int sh, input bit rl);
        logic [31:0] e;
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < H; y++)
                for (int j = 0; j < W / 4; j++) begin
                    for (int b = 0; b < 4; b++) e[8*b +: 8] = exp_px(4 * j + b, y, w, p, sh, rl);
                    chk($sformatf("%s c%0d y%0d j%0d", tag, c, y, j), mem[OB + c * 8 + y * 2 + j], e);
                end
    endtask

    // hold: keep start high for the whole job; poke: extra start edge while busy
    task automatic run_job(input string tag, input logic [3:0] sh, input logic rl,
                           input bit hold, input bit poke, input int exp_tx, input bit exp_ok);
        int f0, d0, v0, cyc;
        f0 = n_fire; d0 = n_done; v0 = viol;
        cfg_shift = sh; cfg_relu = rl;
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " err_cleared"}, 32'(err), 32'd0);
        if (!hold) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 20) start = 1'b1;
            if (poke && cyc == 22) start = 1'b0;
        end
        chk({tag, " finished_in_time"}, 32'(cyc < 3000), 32'd1);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk({tag, " transactions"}, 32'(n_fire - f0), 32'(exp_tx));
        chk({tag, " done_pulses"}, 32'(n_done - d0), exp_ok ? 32'd1 : 32'd0);
        chk({tag, " err"}, 32'(err), exp_ok ? 32'd0 : 32'd1);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        chk({tag, " protocol_violations"}, 32'(viol - v0), 32'd0);
        $display("job %s: %0d transactions, %0d done, err=%0d", tag, n_fire - f0, n_done - d0, err);
    endtask

    initial begin : main
        int f0, cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst cmd_addr", cmd_addr, 32'd0);
        chk("rst cmd_wmask", 32'(cmd_wmask), 32'd0);
        chk("rst rsp_ready", 32'(rsp_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        load_identity();
        run_job("identity", 4'd0, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk_ramp("identity");

        bp_en = 1'b1;
        load_identity();
        run_job("identity_bp_hold", 4'd0, 1'b0, 1'b1, 1'b0, 38, 1'b1);
        chk_ramp("identity_bp");
        bp_en = 1'b0;

        load_const(8'd1, 8'd1);
        run_job("padding_poke", 4'd0, 1'b0, 1'b0, 1'b1, 38, 1'b1);
        chk("padding first word", mem[OB], 32'h06060604);
        chk_const("padding", 1, 1, 0, 1'b0);

        load_const(8'd127, 8'd127);
        run_job("saturate", 4'd0, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk_const("saturate", 127, 127, 0, 1'b0);

        load_const(8'hFF, 8'd1);
        run_job("negative", 4'd0, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk("negative interior", mem[OB + 3], 32'hFAF7F7F7);
        chk_const("negative", -1, 1, 0, 1'b0);

        load_const(8'hFF, 8'd1);
        run_job("relu", 4'd0, 1'b1, 1'b0, 1'b0, 38, 1'b1);
        chk_const("relu", -1, 1, 0, 1'b1);

        load_const(8'd1, 8'd1);
        run_job("shift2", 4'd2, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk("shift2 interior", mem[OB + 3], 32'h01020202);
        chk_const("shift2", 1, 1, 2, 1'b0);

        load_const(8'hFF, 8'd1);
        run_job("shift2_neg", 4'd2, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk_const("shift2_neg", -1, 1, 2, 1'b0);

        load_identity();
        err_at = rsp_cnt + 5;
        run_job("bus_error", 4'd0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        err_at = -1;
        load_identity();
        run_job("after_error", 4'd0, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk_ramp("after_error");

        // Reset while a write command is on the bus
        load_identity();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(cmd_valid && !cmd_read) && cyc < 500);
        chk("midrst write_seen", 32'(cyc < 500), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst addr", cmd_addr, 32'd0);
        chk("midrst wdata", cmd_wdata, 32'd0);
        chk("midrst wmask", 32'(cmd_wmask), 32'd0);
        chk("midrst read", 32'(cmd_read), 32'd0);
        chk("midrst rsp_ready", 32'(rsp_ready), 32'd1);
        f0 = n_fire;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst no_commands", 32'(n_fire - f0), 32'd0);
        chk("midrst still_idle", 32'(busy), 32'd0);

        load_const(8'd1, 8'd1);
        run_job("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 38, 1'b1);
        chk_const("post_reset", 1, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
